// File: rtl/keypad_matrix_emulator.sv
// Responder end of a 4x4 keypad scan interface: plays back one timed key press per
// host request (bounce-in, hold, bounce-out, gap) and answers column strobes on the rows.
module keypad_matrix_emulator #(
   parameter int BOUNCE_CYCLES = 8,
   parameter int BOUNCE_PERIOD = 2,
   parameter int HOLD_CYCLES   = 64,
   parameter int GAP_CYCLES    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] cols,
   output logic [3:0] rows,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic       key_ready,
   output logic       pressed,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      BOUNCE_IN,
      HOLD,
      BOUNCE_OUT,
      GAP
   } state_e;

   localparam int MAX_AB  = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
   localparam int MAX_LEN = (MAX_AB > GAP_CYCLES) ? MAX_AB : GAP_CYCLES;
   localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int SW      = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;

   localparam int BC_LAST   = (BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0;
   localparam int HOLD_LAST = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
   localparam int GAP_LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam int BP_LAST   = (BOUNCE_PERIOD > 0) ? BOUNCE_PERIOD - 1 : 0;

   localparam logic [CW-1:0] BC_END   = CW'(BC_LAST);
   localparam logic [CW-1:0] HOLD_END = CW'(HOLD_LAST);
   localparam logic [CW-1:0] GAP_END  = CW'(GAP_LAST);
   localparam logic [SW-1:0] SUB_END  = SW'(BP_LAST);

   state_e        state_q, state_d;
   logic [CW-1:0] phaseCnt_q, phaseCnt_d;
   logic [SW-1:0] subCnt_q, subCnt_d;
   logic [3:0]    code_q, code_d;
   logic          pressed_q, pressed_d;
   logic          entering;
   logic          subWrap;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         phaseCnt_q <= '0;
         subCnt_q   <= '0;
         code_q     <= '0;
         pressed_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         phaseCnt_q <= phaseCnt_d;
         subCnt_q   <= subCnt_d;
         code_q     <= code_d;
         pressed_q  <= pressed_d;
      end
   end

   // Zero-length bounce and gap phases are skipped by jumping straight past them.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      unique case (state_q)
         IDLE: begin
            if (key_valid) begin
               code_d = key_code;
               if (BOUNCE_CYCLES > 0) state_d = BOUNCE_IN;
               else                   state_d = HOLD;
            end
         end
         BOUNCE_IN: begin
            if (phaseCnt_q == BC_END) state_d = HOLD;
         end
         HOLD: begin
            if (phaseCnt_q == HOLD_END) begin
               if (BOUNCE_CYCLES > 0)   state_d = BOUNCE_OUT;
               else if (GAP_CYCLES > 0) state_d = GAP;
               else                     state_d = IDLE;
            end
         end
         BOUNCE_OUT: begin
            if (phaseCnt_q == BC_END) begin
               if (GAP_CYCLES > 0) state_d = GAP;
               else                state_d = IDLE;
            end
         end
         GAP: begin
            if (phaseCnt_q == GAP_END) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      entering   = (state_d != state_q);
      subWrap    = (subCnt_q == SUB_END);
      phaseCnt_d = (entering || state_q == IDLE) ? '0 : phaseCnt_q + 1'b1;
      subCnt_d   = (entering || subWrap) ? '0 : subCnt_q + 1'b1;
   end

   // Bounce contact flips whenever the sub-counter wraps, i.e. every BOUNCE_PERIOD cycles.
   always_comb begin
      pressed_d = 1'b0;
      unique case (state_d)
         HOLD:       pressed_d = 1'b1;
         BOUNCE_IN:  pressed_d = entering ? 1'b1 : (pressed_q ^ subWrap);
         BOUNCE_OUT: pressed_d = entering ? 1'b0 : (pressed_q ^ subWrap);
         default:    pressed_d = 1'b0;
      endcase

      key_ready = (state_q == IDLE);
      busy      = (state_q != IDLE);
      pressed   = pressed_q;
      rows      = (pressed_q && cols[code_q[1:0]]) ? (4'b0001 << code_q[3:2]) : 4'b0000;
   end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Bench for keypad_matrix_emulator: a default instance and a fast no-bounce instance
// share stimulus and are both checked every cycle against a press-timeline model.
module tb_keypad_matrix_emulator;

   localparam int A_BC = 8, A_BP = 2, A_HOLD = 64, A_GAP = 16;
   localparam int F_BC = 0, F_BP = 2, F_HOLD = 4, F_GAP = 0;
   localparam int A_TOTAL = 2 * A_BC + A_HOLD + A_GAP;
   localparam int F_TOTAL = 2 * F_BC + F_HOLD + F_GAP;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] cols;
   logic [3:0] keyCode;
   logic       keyValid;
   logic [3:0] rowsA, rowsF;
   logic       readyA, readyF, pressedA, pressedF, busyA, busyF;

   int         errors = 0;
   int         checks = 0;
   int         sinceA = -1;
   int         sinceF = -1;
   logic [3:0] codeA  = 4'h0;
   logic [3:0] codeF  = 4'h0;
   string      phase  = "init";

   keypad_matrix_emulator #(
      .BOUNCE_CYCLES(A_BC), .BOUNCE_PERIOD(A_BP), .HOLD_CYCLES(A_HOLD), .GAP_CYCLES(A_GAP)
   ) dut (
      .clk(clk), .rst(rst), .cols(cols), .rows(rowsA), .key_code(keyCode),
      .key_valid(keyValid), .key_ready(readyA), .pressed(pressedA), .busy(busyA)
   );

   keypad_matrix_emulator #(
      .BOUNCE_CYCLES(F_BC), .BOUNCE_PERIOD(F_BP), .HOLD_CYCLES(F_HOLD), .GAP_CYCLES(F_GAP)
   ) dutFast (
      .clk(clk), .rst(rst), .cols(cols), .rows(rowsF), .key_code(keyCode),
      .key_valid(keyValid), .key_ready(readyF), .pressed(pressedF), .busy(busyF)
   );

   always #5 clk = ~clk;

   // Contact state idx cycles after acceptance, read straight off the press timeline.
   function automatic logic expPressed(input int idx, input int bc, input int bp, input int hold);
      if (idx < 0)            return 1'b0;
      if (idx < bc)           return ((idx / bp) % 2) == 0;
      if (idx < bc + hold)    return 1'b1;
      if (idx < 2 * bc + hold) return (((idx - bc - hold) / bp) % 2) == 1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] expRows(input logic p, input logic [3:0] code, input logic [3:0] c);
      logic [3:0] r;
      r = 4'b0000;
      for (int i = 0; i < 4; i++)
         r[i] = p && (i == int'(code[3:2])) && c[code[1:0]];
      return r;
   endfunction

   task automatic compareValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      logic pA, pF;
      pA = expPressed(sinceA, A_BC, A_BP, A_HOLD);
      pF = expPressed(sinceF, F_BC, F_BP, F_HOLD);
      compareValue({phase, " pressedA"}, 32'(pressedA), 32'(pA));
      compareValue({phase, " rowsA"}, 32'(rowsA), 32'(expRows(pA, codeA, cols)));
      compareValue({phase, " readyA"}, 32'(readyA), 32'(sinceA < 0));
      compareValue({phase, " busyA"}, 32'(busyA), 32'(sinceA >= 0));
      compareValue({phase, " pressedF"}, 32'(pressedF), 32'(pF));
      compareValue({phase, " rowsF"}, 32'(rowsF), 32'(expRows(pF, codeF, cols)));
      compareValue({phase, " readyF"}, 32'(readyF), 32'(sinceF < 0));
      compareValue({phase, " busyF"}, 32'(busyF), 32'(sinceF >= 0));
   endtask

   task automatic applyStimulus(input logic r, input logic v, input logic [3:0] code, input logic [3:0] c);
      logic accA, accF;
      rst      = r;
      keyValid = v;
      keyCode  = code;
      cols     = c;
      accA = !r && v && (sinceA < 0);
      accF = !r && v && (sinceF < 0);
      @(posedge clk);
      #1;
      if (r) sinceA = -1;
      else if (accA) begin sinceA = 0; codeA = code; end
      else if (sinceA >= 0) begin sinceA++; if (sinceA >= A_TOTAL) sinceA = -1; end
      if (r) sinceF = -1;
      else if (accF) begin sinceF = 0; codeF = code; end
      else if (sinceF >= 0) begin sinceF++; if (sinceF >= F_TOTAL) sinceF = -1; end
      checkOutput();
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'h0, 4'($urandom_range(0, 15)));
   endtask

   initial begin
      int         lowCount;
      logic [7:0] binExp;
      binExp = 8'b11001100;

      phase = "reset";
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);

      phase = "T1 abort";
      applyStimulus(1'b0, 1'b1, 4'h3, 4'b1000);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 4'h3, 4'b1000);
      compareValue("T1 rowsInHold", 32'(rowsA), 32'h1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'h3, 4'b1000);
      applyStimulus(1'b0, 1'b0, 4'h3, 4'b1000);
      compareValue("T1 rowsAfter", 32'(rowsA), 32'h0);
      compareValue("T1 pressedAfter", 32'(pressedA), 32'h0);
      compareValue("T1 readyAfter", 32'(readyA), 32'h1);
      compareValue("T1 busyAfter", 32'(busyA), 32'h0);

      phase = "T2 scan";
      applyStimulus(1'b0, 1'b1, 4'h6, 4'b0001);
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 4'h6, 4'b0001);
      compareValue("T2 col0", 32'(rowsA), 32'h0);
      applyStimulus(1'b0, 1'b0, 4'h6, 4'b0010);
      compareValue("T2 col1", 32'(rowsA), 32'h0);
      applyStimulus(1'b0, 1'b0, 4'h6, 4'b0100);
      compareValue("T2 col2", 32'(rowsA), 32'h2);
      applyStimulus(1'b0, 1'b0, 4'h6, 4'b1000);
      compareValue("T2 col3", 32'(rowsA), 32'h0);
      applyStimulus(1'b0, 1'b0, 4'h6, 4'b0000);
      compareValue("T2 colNone", 32'(rowsA), 32'h0);
      drain(100);

      phase = "T3 profile";
      lowCount = 0;
      for (int i = 0; i < 97; i++) begin
         applyStimulus(1'b0, (i == 0), 4'hF, 4'b1000);
         if (!readyA) lowCount++;
         if (i < 8) compareValue("T3 bounceInRows", 32'(rowsA), binExp[7 - i] ? 32'h8 : 32'h0);
      end
      compareValue("T3 readyLowCycles", 32'(lowCount), 32'd96);
      compareValue("T3 readyBack", 32'(readyA), 32'h1);

      phase = "T4 queued";
      applyStimulus(1'b0, 1'b1, 4'h0, 4'($urandom_range(0, 15)));
      for (int i = 1; i <= 97; i++) begin
         applyStimulus(1'b0, 1'b1, 4'h5, 4'($urandom_range(0, 15)));
         if (i == 95) compareValue("T4 stillBusy", 32'(readyA), 32'h0);
         if (i == 96) compareValue("T4 readyReturns", 32'(readyA), 32'h1);
         if (i == 97) compareValue("T4 secondAccepted", 32'(readyA), 32'h0);
      end
      drain(100);

      phase = "T5 noBounce";
      applyStimulus(1'b0, 1'b1, 4'h9, 4'b0010);
      compareValue("T5 rows0", 32'(rowsF), 32'h4);
      for (int i = 1; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 4'h9, 4'b0010);
         compareValue("T5 rowsHold", 32'(rowsF), 32'h4);
      end
      compareValue("T5 busyAt3", 32'(readyF), 32'h0);
      applyStimulus(1'b0, 1'b0, 4'h9, 4'b0010);
      compareValue("T5 rowsEnd", 32'(rowsF), 32'h0);
      compareValue("T5 readyEnd", 32'(readyF), 32'h1);
      drain(100);

      phase = "T6 allCols";
      applyStimulus(1'b0, 1'b1, 4'hC, 4'b1111);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 4'hC, 4'b1111);
      compareValue("T6 rowsAllCols", 32'(rowsA), 32'h8);
      drain(100);

      phase = "random";
      for (int i = 0; i < 800; i++)
         applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
